// File: rtl/map_merger_pkg.sv
// Shared definitions for the map merger: mode encodings, default sizes,
// latched configuration record and the requantise/saturate helper.
package map_merger_pkg;

  localparam logic [1:0] MODE_MERGE = 2'd0;
  localparam logic [1:0] MODE_3X3   = 2'd1;
  localparam logic [1:0] MODE_1X1   = 2'd2;
  localparam logic [1:0] MODE_ID    = 2'd3;

  localparam int DEF_LANES = 4;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_MID_W = 24;
  localparam int DEF_ID_W  = 8;
  localparam int DEF_Q_W   = 8;
  localparam int DEF_PACK  = 2;

  typedef struct packed {
    logic [4:0] shift;
    logic       relu;
    logic [1:0] mode;
  } cfg_t;

  // ReLU, round-half-up right shift, then clamp to a signed q_w-bit range.
  // Works in 64 bits so the rounding add can never wrap for ACC_W <= 60.
  // q_w must not exceed 32.
  function automatic logic signed [31:0] quant_sat(input logic signed [63:0] s,
                                                   input logic [4:0]         shift,
                                                   input logic               relu,
                                                   input int                 q_w);
    logic signed [63:0] v;
    logic signed [63:0] r;
    logic signed [63:0] qmax;
    logic signed [63:0] qmin;
    v = (relu && (s < 64'sd0)) ? 64'sd0 : s;
    if (shift != 5'd0) begin
      r = (v + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    end else begin
      r = v;
    end
    qmax = (64'sd1 <<< (q_w - 1)) - 64'sd1;
    qmin = -(64'sd1 <<< (q_w - 1));
    if (r > qmax) begin
      r = qmax;
    end else if (r < qmin) begin
      r = qmin;
    end
    return 32'(r);
  endfunction

endpackage

// File: rtl/map_merger_pack_if.sv
// Valid/ready bundle between psum_acc (input beats) and omap_biu (packed words).
interface map_merger_pack_if
  import map_merger_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = DEF_ACC_W,
  parameter int MID_W = DEF_MID_W,
  parameter int ID_W  = DEF_ID_W,
  parameter int Q_W   = DEF_Q_W,
  parameter int PACK  = DEF_PACK
);
  localparam int IN_W  = LANES * (ID_W + MID_W + ACC_W);
  localparam int OUT_W = LANES * Q_W * PACK;

  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             in_vld;
  logic             in_rdy;
  logic [OUT_W-1:0] out_data;
  logic [PACK-1:0]  out_keep;
  logic             out_last;
  logic             out_vld;
  logic             out_rdy;

  // Environment side: produces beats, consumes words.
  modport master (
    output in_data, in_last, in_vld, out_rdy,
    input  in_rdy, out_data, out_keep, out_last, out_vld
  );

  // Merger side.
  modport slave (
    input  in_data, in_last, in_vld, out_rdy,
    output in_rdy, out_data, out_keep, out_last, out_vld
  );
endinterface

// File: rtl/map_merger_lane.sv
// Combinational per-lane merge, ReLU, rounding shift and saturation.
module map_merger_lane
  import map_merger_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int MID_W = DEF_MID_W,
  parameter int ID_W  = DEF_ID_W,
  parameter int Q_W   = DEF_Q_W
) (
  input  logic signed [ACC_W-1:0] psum3,
  input  logic signed [MID_W-1:0] psum1,
  input  logic signed [ID_W-1:0]  ident,
  input  cfg_t                    cfg,
  output logic signed [Q_W-1:0]   q
);
  // Two guard bits cover the three-operand sum without overflow.
  localparam int S_W = ACC_W + 2;

  logic signed [S_W-1:0] s;
  logic signed [31:0]    q_full;

  // Select the source, then requantise to Q_W bits.
  always_comb begin
    s = '0;
    case (cfg.mode)
      MODE_3X3: s = S_W'(psum3);
      MODE_1X1: s = S_W'(psum1);
      MODE_ID:  s = S_W'(ident);
      default:  s = S_W'(ident) + S_W'(psum1) + S_W'(psum3);
    endcase
    q_full = quant_sat(64'(s), cfg.shift, cfg.relu, Q_W);
    q      = Q_W'(q_full);
  end

endmodule

// File: rtl/map_merger_pack.sv
// Multi-lane psum merger: per-lane merge/requantise (S1) followed by a pack
// buffer (S2) that gathers PACK beats into one wide word for the omap BIU.
module map_merger_pack
  import map_merger_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = DEF_ACC_W,
  parameter int MID_W = DEF_MID_W,
  parameter int ID_W  = DEF_ID_W,
  parameter int Q_W   = DEF_Q_W,
  parameter int PACK  = DEF_PACK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  input  logic [1:0]              cfg_mode,
  map_merger_pack_if.slave        bus
);
  localparam int IN_LW  = ID_W + MID_W + ACC_W;
  localparam int BEAT_W = LANES * Q_W;
  localparam int WORD_W = BEAT_W * PACK;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(PACK - 1);

  cfg_t              cfg_in;
  cfg_t              cfg_q;
  cfg_t              cfg_p0;
  logic              first_q;
  logic              rdy_p0;
  logic              acc_p0;
  logic [BEAT_W-1:0] q_p0;

  logic              vld_p1;
  logic              last_p1;
  logic [BEAT_W-1:0] q_p1;

  logic              vld_p2;
  logic              last_p2;
  logic              take_p2;
  logic [WORD_W-1:0] word_p2;
  logic [PACK-1:0]   keep_p2;
  logic [SLOT_W-1:0] slot_p2;

  logic              vld_n;
  logic              last_n;
  logic [WORD_W-1:0] word_n;
  logic [PACK-1:0]   keep_n;
  logic [SLOT_W-1:0] slot_n;

  assign cfg_in.shift = cfg_shift;
  assign cfg_in.relu  = cfg_relu;
  assign cfg_in.mode  = cfg_mode;

  // The first beat of a tile uses the live cfg; later beats use the latched copy.
  assign cfg_p0  = first_q ? cfg_in : cfg_q;

  // S2 accepts when it is not holding a finished word, or that word drains now.
  assign take_p2 = !vld_p2 || bus.out_rdy;
  assign rdy_p0  = !vld_p1 || take_p2;
  assign acc_p0  = bus.in_vld && rdy_p0;

  assign bus.in_rdy   = rdy_p0;
  assign bus.out_vld  = vld_p2;
  assign bus.out_data = word_p2;
  assign bus.out_keep = keep_p2;
  assign bus.out_last = last_p2;

  // Capture cfg on the first accepted beat of each tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '0;
      first_q <= 1'b1;
    end else if (acc_p0) begin
      if (first_q) begin
        cfg_q <= cfg_in;
      end
      first_q <= bus.in_last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    map_merger_lane #(
      .ACC_W (ACC_W),
      .MID_W (MID_W),
      .ID_W  (ID_W),
      .Q_W   (Q_W)
    ) u_lane (
      .psum3 (bus.in_data[i*IN_LW +: ACC_W]),
      .psum1 (bus.in_data[i*IN_LW + ACC_W +: MID_W]),
      .ident (bus.in_data[i*IN_LW + ACC_W + MID_W +: ID_W]),
      .cfg   (cfg_p0),
      .q     (q_p0[i*Q_W +: Q_W])
    );
  end

  // S1: register the quantised beat whenever the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      q_p1    <= '0;
    end else if (rdy_p0) begin
      vld_p1 <= bus.in_vld;
      if (bus.in_vld) begin
        q_p1    <= q_p0;
        last_p1 <= bus.in_last;
      end
    end
  end

  // S2 next state: drain a finished word, then drop the S1 beat into its slot.
  always_comb begin
    vld_n  = vld_p2;
    last_n = last_p2;
    word_n = word_p2;
    keep_n = keep_p2;
    slot_n = slot_p2;
    if (vld_p2 && bus.out_rdy) begin
      vld_n  = 1'b0;
      last_n = 1'b0;
      word_n = '0;
      keep_n = '0;
    end
    if (vld_p1 && take_p2) begin
      word_n[slot_p2*BEAT_W +: BEAT_W] = q_p1;
      keep_n[slot_p2] = 1'b1;
      if (last_p1 || (slot_p2 == SLOT_MAX)) begin
        vld_n  = 1'b1;
        last_n = last_p1;
        slot_n = '0;
      end else begin
        slot_n = slot_p2 + SLOT_W'(1);
      end
    end
  end

  // S2: pack buffer, slot counter and output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      word_p2 <= '0;
      keep_p2 <= '0;
      slot_p2 <= '0;
    end else begin
      vld_p2  <= vld_n;
      last_p2 <= last_n;
      word_p2 <= word_n;
      keep_p2 <= keep_n;
      slot_p2 <= slot_n;
    end
  end

endmodule

// File: tb/tb_map_merger_pack.sv
// Directed bench for map_merger_pack with a reference model and word scoreboard.
module tb_map_merger_pack;
  localparam int LANES = 4;
  localparam int IN_W  = 256;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  keep;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] cfg_shift;
  logic       cfg_relu;
  logic [1:0] cfg_mode;

  int checks   = 0;
  int failures = 0;
  int n_pop    = 0;

  exp_t        sb[$];
  logic [63:0] last_data;
  logic [1:0]  last_keep;
  logic        last_last;

  // reference model state
  bit          m_first;
  logic [4:0]  m_sh;
  bit          m_relu;
  logic [1:0]  m_mode;
  int          m_slot;
  logic [63:0] m_word;
  logic [1:0]  m_keep;

  map_merger_pack_if #(.LANES(4), .ACC_W(32), .MID_W(24), .ID_W(8), .Q_W(8), .PACK(2)) bus ();

  map_merger_pack #(.LANES(4), .ACC_W(32), .MID_W(24), .ID_W(8), .Q_W(8), .PACK(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .cfg_mode  (cfg_mode),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(input longint id, input longint m, input longint a,
                                       input int mode, input int sh, input bit relu);
    longint s;
    longint r;
    case (mode)
      1:       s = a;
      2:       s = m;
      3:       s = id;
      default: s = id + m + a;
    endcase
    if (relu && s < 0) s = 0;
    if (sh > 0) r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    else        r = s;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_first = 1'b1;
    m_sh    = '0;
    m_relu  = 1'b0;
    m_mode  = '0;
    m_slot  = 0;
    m_word  = '0;
    m_keep  = '0;
  endtask

  task automatic model_accept(input logic [IN_W-1:0] d, input logic l);
    exp_t e;
    longint a;
    longint m;
    longint id;
    if (m_first) begin
      m_sh   = cfg_shift;
      m_relu = cfg_relu;
      m_mode = cfg_mode;
    end
    m_first = l;
    for (int i = 0; i < LANES; i++) begin
      a  = longint'($signed(d[i*64 +: 32]));
      m  = longint'($signed(d[i*64 + 32 +: 24]));
      id = longint'($signed(d[i*64 + 56 +: 8]));
      m_word[m_slot*32 + i*8 +: 8] = ref_q(id, m, a, int'(m_mode), int'(m_sh), m_relu);
    end
    m_keep[m_slot] = 1'b1;
    if (l || m_slot == 1) begin
      e.data = m_word;
      e.keep = m_keep;
      e.last = l;
      sb.push_back(e);
      m_word = '0;
      m_keep = '0;
      m_slot = 0;
    end else begin
      m_slot++;
    end
  endtask

  function automatic logic [IN_W-1:0] mk_rand();
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [IN_W-1:0] mk(input logic [7:0] id0, input logic [23:0] m0,
                                         input logic [31:0] a0);
    logic [IN_W-1:0] d;
    d = mk_rand();
    d[63:0] = {id0, m0, a0};
    return d;
  endfunction

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int n = 0;
    bus.in_data = d;
    bus.in_last = l;
    bus.in_vld  = 1'b1;
    @(negedge clk);
    while (!bus.in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_rdy_wait", 64'(bus.in_rdy), 64'd1);
    if (bus.in_rdy) model_accept(d, l);
    @(posedge clk);
    #1;
    bus.in_vld  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pop and compare every transferred word.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_vld && bus.out_rdy) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("word_data", bus.out_data, e.data);
        chk("word_keep", 64'(bus.out_keep), 64'(e.keep));
        chk("word_last", 64'(bus.out_last), 64'(e.last));
        last_data = bus.out_data;
        last_keep = bus.out_keep;
        last_last = bus.out_last;
        n_pop++;
      end
    end
  end

  initial begin
    int pop0;
    rst_n       = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    cfg_shift   = 5'd0;
    cfg_relu    = 1'b0;
    cfg_mode    = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld",  64'(bus.out_vld),  64'd0);
    chk("rst_out_keep", 64'(bus.out_keep), 64'd0);
    chk("rst_out_data", bus.out_data,      64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_in_rdy",   64'(bus.in_rdy),   64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // merged sum with rounding shift 8
    cfg_mode = 2'd0; cfg_shift = 5'd8; cfg_relu = 1'b0;
    send(mk(8'd5, 24'h000100, 32'h00000280), 1'b0);
    send(mk_rand(), 1'b1);
    drain("t1");
    chk("t1_lane0", 64'(last_data[7:0]), 64'd4);
    chk("t1_keep",  64'(last_keep),      64'd3);

    // ReLU on and off with a large negative 3x3 psum, one-beat tiles
    cfg_shift = 5'd0; cfg_relu = 1'b1;
    send(mk(8'd0, 24'd0, 32'(-1000)), 1'b1);
    drain("t2a");
    chk("t2_relu_lane0", 64'(last_data[7:0]), 64'd0);
    chk("t2_relu_keep",  64'(last_keep),      64'd1);
    cfg_relu = 1'b0;
    send(mk(8'd0, 24'd0, 32'(-1000)), 1'b1);
    drain("t2b");
    chk("t2_sat_lane0", 64'(last_data[7:0]), 64'h80);

    // three-beat tile: second word partial
    cfg_mode = 2'd1; cfg_shift = 5'd3;
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b1);
    drain("t3");
    chk("t3_keep",  64'(last_keep),         64'd1);
    chk("t3_last",  64'(last_last),         64'd1);
    chk("t3_upper", 64'(last_data[63:32]),  64'd0);

    // the other result selects
    cfg_mode = 2'd2; cfg_shift = 5'd5; cfg_relu = 1'b1;
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b1);
    cfg_mode = 2'd3; cfg_shift = 5'd1; cfg_relu = 1'b0;
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b1);
    drain("t_modes");

    // cfg change mid-tile is ignored until the next tile
    cfg_mode = 2'd0; cfg_shift = 5'd4;
    send(mk(8'd0, 24'd0, 32'd56), 1'b0);
    cfg_shift = 5'd0;
    send(mk_rand(), 1'b0);
    send(mk(8'd0, 24'd0, 32'd56), 1'b1);
    drain("t5a");
    chk("t5_old_shift", 64'(last_data[7:0]), 64'd4);
    send(mk(8'd0, 24'd0, 32'd56), 1'b1);
    drain("t5b");
    chk("t5_new_shift", 64'(last_data[7:0]), 64'd56);

    // backpressure: stall output, then release after 10 cycles
    cfg_shift = 5'd6;
    pop0 = n_pop;
    bus.out_rdy = 1'b0;
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b0);
    @(negedge clk);
    chk("stall_in_rdy",  64'(bus.in_rdy),  64'd0);
    chk("stall_out_vld", 64'(bus.out_vld), 64'd1);
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        bus.out_rdy = 1'b1;
      end
    join_none
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(mk_rand(), (i == 4) ? 1'b1 : 1'b0);
    drain("t4");
    chk("stall_words", 64'(n_pop - pop0), 64'd4);

    // reset while a half group sits in S2
    cfg_shift = 5'd2;
    send(mk_rand(), 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_keep", 64'(bus.out_keep), 64'd1);
    chk("pre_rst_vld",  64'(bus.out_vld),  64'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_vld",  64'(bus.out_vld),  64'd0);
    chk("mid_rst_keep", 64'(bus.out_keep), 64'd0);
    chk("mid_rst_data", bus.out_data,      64'd0);
    chk("mid_rst_last", 64'(bus.out_last), 64'd0);
    chk("mid_rst_sb",   64'(sb.size()),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cfg_shift = 5'd3; cfg_mode = 2'd0;
    send(mk_rand(), 1'b0);
    send(mk_rand(), 1'b1);
    drain("t6");
    chk("t6_keep", 64'(last_keep), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
